// File: rtl/cfg_mux_n.sv
// cfg_mux_n: register-bus fan-out to NUM_SLV slaves with tracked, timed-out reads
module cfg_mux_n #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W = 14,
    parameter int SUB_ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] UNMAP_DATA = 32'h5A5A_5A5A,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_wr_en,
    input  logic                      reg_rd_en,
    input  logic [DATA_W/8-1:0]       reg_byte_enable,
    input  logic [ADDR_W-1:0]         reg_addr,
    input  logic [DATA_W-1:0]         reg_wr_data,
    output logic [DATA_W-1:0]         reg_rd_data,
    output logic                      reg_rd_data_vld,
    output logic                      reg_wait_request,
    output logic [SUB_ADDR_W-1:0]     sub_reg_addr,
    output logic [DATA_W-1:0]         sub_wr_data,
    output logic [DATA_W/8-1:0]       sub_byte_enable,
    output logic [NUM_SLV-1:0]        slv_wr_en,
    output logic [NUM_SLV-1:0]        slv_rd_en,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rd_data,
    input  logic [NUM_SLV-1:0]        slv_rd_data_vld,
    output logic                      err_timeout,
    output logic [15:0]               err_cnt,
    input  logic                      err_cnt_clr
);
    localparam int IW = ADDR_W - SUB_ADDR_W;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t state, state_nxt;
    logic [IW-1:0] idx, lidx;
    logic [CW-1:0] cnt;
    logic [NUM_SLV-1:0] vld_sh;
    logic [NUM_SLV*DATA_W-1:0] data_sh;
    logic mapped, wr_go, rd_go, rd_unmap, hit, tmo;

    assign idx = reg_addr[ADDR_W-1:SUB_ADDR_W];
    assign mapped = 32'(idx) < NUM_SLV;
    assign wr_go = state == IDLE && reg_wr_en;
    assign rd_go = state == IDLE && reg_rd_en && !reg_wr_en && mapped;
    assign rd_unmap = state == IDLE && reg_rd_en && !reg_wr_en && !mapped;
    // shifting keeps the latched-slave select legal for any NUM_SLV
    assign vld_sh = slv_rd_data_vld >> lidx;
    assign data_sh = slv_rd_data >> (lidx * DATA_W);
    assign hit = state == RD_WAIT && vld_sh[0];
    assign tmo = state == RD_WAIT && !hit && cnt == CW'(TIMEOUT - 1);
    assign reg_wait_request = state == RD_WAIT;
    assign sub_reg_addr = reg_addr[SUB_ADDR_W-1:0];
    assign sub_wr_data = reg_wr_data;
    assign sub_byte_enable = reg_byte_enable;
    assign slv_wr_en = (wr_go && mapped) ? NUM_SLV'(1) << idx : '0;
    assign slv_rd_en = rd_go ? NUM_SLV'(1) << idx : '0;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // next state: enter wait on a mapped read, leave on valid or timeout
    always_comb begin
        state_nxt = rd_go ? RD_WAIT : (hit || tmo) ? IDLE : state;
    end

    // read response, wait counter, latched slave and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rd_data <= '0;
            reg_rd_data_vld <= 1'b0;
            err_timeout <= 1'b0;
            err_cnt <= '0;
            cnt <= '0;
            lidx <= '0;
        end else begin
            reg_rd_data_vld <= rd_unmap || hit || tmo;
            err_timeout <= tmo;
            if (rd_unmap) reg_rd_data <= UNMAP_DATA;
            else if (hit) reg_rd_data <= data_sh[DATA_W-1:0];
            else if (tmo) reg_rd_data <= ERR_DATA;
            if (rd_go) begin
                cnt <= '0;
                lidx <= idx;
            end else if (state == RD_WAIT) cnt <= cnt + 1'b1;
            if (err_cnt_clr) err_cnt <= '0;
            else if (tmo && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: doc/cfg_mux_n.md
# cfg_mux_n

Parametrised register-bus fan-out that sits between the host register port and `NUM_SLV` sub-block register files. It decodes the upper address bits to one slave and forwards writes in a single cycle. Reads are tracked through a small FSM that waits a variable number of cycles for the slave's read-valid. Unmapped reads return a fixed pattern, stalled reads time out with an error pattern, and timeouts are counted for diagnostics.

## Interface
Parameters:
- `NUM_SLV`, 4, number of slaves; range 1 to 2^(`ADDR_W`-`SUB_ADDR_W`).
- `ADDR_W`, 14, host address width.
- `SUB_ADDR_W`, 12, slave-local address width; slave index = `reg_addr[ADDR_W-1:SUB_ADDR_W]`.
- `DATA_W`, 32, data width, multiple of 8.
- `TIMEOUT`, 255, read-wait cycles before abort; must be ≥ 1.
- `UNMAP_DATA`, 32'h5A5A_5A5A, read data for an unmapped index.
- `ERR_DATA`, 32'hDEAD_BEEF, read data on timeout.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `reg_wr_en`  in  1  host write request.
- `reg_rd_en`  in  1  host read request.
- `reg_byte_enable`  in  `DATA_W`/8  write byte enables.
- `reg_addr`  in  `ADDR_W`  host address.
- `reg_wr_data`  in  `DATA_W`  write data.
- `reg_rd_data`  out  `DATA_W`  registered read data.
- `reg_rd_data_vld`  out  1  one-cycle read-data strobe.
- `reg_wait_request`  out  1  high = host command not accepted this cycle.
- `sub_reg_addr`  out  `SUB_ADDR_W`  = `reg_addr[SUB_ADDR_W-1:0]`, combinational.
- `sub_wr_data`, `sub_byte_enable`  out  `DATA_W`, `DATA_W`/8  pass-through of the host signals.
- `slv_wr_en`  out  `NUM_SLV`  one-hot write strobe.
- `slv_rd_en`  out  `NUM_SLV`  one-hot read strobe.
- `slv_rd_data`  in  `NUM_SLV`*`DATA_W`  packed; slave i occupies `[i*DATA_W +: DATA_W]`.
- `slv_rd_data_vld`  in  `NUM_SLV`  per-slave read valid.
- `err_timeout`  out  1  one-cycle pulse when a read times out.
- `err_cnt`  out  16  saturating timeout count.
- `err_cnt_clr`  in  1  synchronous clear of `err_cnt`.

## Operation
- FSM states: `IDLE`, `RD_WAIT`.
- `reg_wait_request` = (state == `RD_WAIT`), combinational.
- A command is accepted when (`reg_rd_en` | `reg_wr_en`) is high in `IDLE`.

Writes:
- On acceptance with a mapped index, `slv_wr_en[idx]` is asserted combinationally in the same cycle. The FSM stays in `IDLE`.
- A write to an unmapped index is dropped silently.

Mapped reads:
- On acceptance, `slv_rd_en[idx]` is asserted combinationally in the same cycle.
- `idx` is latched, the wait counter is cleared, and the FSM moves to `RD_WAIT`.

Unmapped reads:
- No `slv_rd_en` is asserted and the FSM stays in `IDLE`.
- Next cycle: `reg_rd_data` = `UNMAP_DATA` and `reg_rd_data_vld` = 1.

`RD_WAIT`:
- Only `slv_rd_data_vld[latched idx]` is observed; valids from other slaves are ignored.
- On valid: the next cycle drives `reg_rd_data` = that slave's data and `reg_rd_data_vld` = 1, and the FSM returns to `IDLE`.
- Otherwise the counter increments. If the counter equals `TIMEOUT`-1 in a cycle with no valid, the read aborts:
  - next cycle: `reg_rd_data` = `ERR_DATA`, `reg_rd_data_vld` = 1, `err_timeout` = 1;
  - `err_cnt` increments, saturating at 16'hFFFF;
  - the FSM returns to `IDLE`.
- A valid arriving in the same cycle the timeout would fire wins: normal data is returned and no error is raised.

Boundary rules:
- `reg_wr_en` and `reg_rd_en` high together: the write executes and the read is dropped.
- A late slave valid arriving in `IDLE` is ignored.
- `err_cnt_clr` together with an increment: the clear wins and `err_cnt` = 0.
- `reg_rd_data` holds its last value between strobes.
- Counter width is $clog2(`TIMEOUT`+1).

## Timing
- Reset values:
  - state = `IDLE`;
  - `reg_rd_data` = 0, `reg_rd_data_vld` = 0, `err_timeout` = 0, `err_cnt` = 0, wait counter = 0;
  - `reg_wait_request` = 0 and all `slv_*_en` = 0 (these follow from the state and inputs).
- Reset asserted in `RD_WAIT` aborts the read with no strobe and no error.
- Write: strobe in the same cycle as acceptance T; the next command can be accepted at T+1.
- Read accepted at T, slave valid at T+k (k ≥ 1): `reg_rd_data_vld` at T+k+1. `reg_wait_request` is high T+1 to T+k, and the next command can be accepted at T+k+1.
- Timeout with no valid: abort response at T+`TIMEOUT`+1.
- Unmapped read: response at T+1, with no wait request.

## Test plan
- Write to 14'h1004 with data 32'hCAFE_0001 and BE 4'hF -> `slv_wr_en` = 4'b0010 for exactly one cycle; `sub_reg_addr` = 12'h004; `reg_wait_request` stays 0.
- Read 14'h2010 with slave 2 returning 32'h1234_5678 three cycles after `slv_rd_en` -> `reg_rd_data_vld` at T+4 with 32'h1234_5678; `reg_wait_request` high T+1..T+3.
- Read of an unmapped index with `NUM_SLV`=3 (address 14'h3000) -> 32'h5A5A_5A5A at T+1; no `slv_rd_en` asserted.
- Read of slave 0 with no valid and `TIMEOUT`=8 -> 32'hDEAD_BEEF and `err_timeout` at T+9; `err_cnt` = 1. A valid arriving late at T+12 is ignored.
- Valid arriving exactly at T+`TIMEOUT` -> slave data returned; `err_cnt` unchanged.
- Simultaneous rd/wr, then `rst_n` pulsed during `RD_WAIT` -> the write strobes and the read is dropped; after the reset pulse all outputs are 0 and the FSM is in `IDLE`.
